pipe_hold_ctrl: RTL and testbench

Pipeline hold/bubble controller for the CPU core. It drives the `hold_en` inputs of the inter-stage pipeline registers and the PC register. It also sequences redirects: a jump, the ROM fetch-latency drain after it, and a jump that must wait behind a bus wait. The pipeline registers only consume `hold_en`; this block decides, cycle by cycle, whether each one holds, loads its default (NOP), or advances.

---
 rtl/pipe_hold_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/bubble controller: stalls, NOP bubbles and PC redirect sequencing.
// Optional stall-cycle performance counter enabled by defining PIPE_HOLD_CTRL_PERF_EN.
module pipe_hold_ctrl #(
  parameter int AW       = 32,
  parameter int ROM_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          ex_busy_i,
  input  logic          bus_wait_i,
  output logic          stall_pc_o,
  output logic          stall_if_id_o,
  output logic          stall_id_ex_o,
  output logic          bubble_if_id_o,
  output logic          bubble_id_ex_o,
  output logic          pc_load_o,
`ifdef PIPE_HOLD_CTRL_PERF_EN
  output logic [31:0]   stall_cycles_o,
`endif
  output logic [AW-1:0] pc_addr_o
);

  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, REDIRECT = 2'd2} state_e;

  localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;

  logic          stall, bubble_if_id, bubble_id_ex, pc_load;
  logic [AW-1:0] pc_addr;

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_addr_d  = pend_addr_q;
    stall        = 1'b0;
    bubble_if_id = 1'b0;
    bubble_id_ex = 1'b0;
    pc_load      = 1'b0;
    pc_addr      = '0;

    if (jump_req_i) begin
      // A jump behaves identically from every state; the newest one always wins.
      if (bus_wait_i) begin
        pend_addr_d = jump_addr_i;
        stall       = 1'b1;
        state_d     = PEND;
      end else begin
        pc_load      = 1'b1;
        pc_addr      = jump_addr_i;
        bubble_if_id = 1'b1;
        bubble_id_ex = 1'b1;
        state_d      = (ROM_WAIT_C != 4'd0) ? REDIRECT : RUN;
        cnt_d        = ROM_WAIT_C;
      end
    end else begin
      case (state_q)
        RUN: begin
          stall = bus_wait_i | ex_busy_i;
        end
        PEND: begin
          if (bus_wait_i) begin
            stall = 1'b1;
          end else begin
            pc_load      = 1'b1;
            pc_addr      = pend_addr_q;
            bubble_if_id = 1'b1;
            bubble_id_ex = 1'b1;
            state_d      = (ROM_WAIT_C != 4'd0) ? REDIRECT : RUN;
            cnt_d        = ROM_WAIT_C;
          end
        end
        REDIRECT: begin
          if (bus_wait_i) begin
            stall = 1'b1;
          end else begin
            bubble_if_id = 1'b1;
            cnt_d        = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
            if (cnt_d == 4'd0) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Outputs are forced low for the whole time reset is high, not just after an edge.
  always_comb begin
    stall_pc_o     = stall & ~rst;
    stall_if_id_o  = stall & ~rst;
    stall_id_ex_o  = stall & ~rst;
    bubble_if_id_o = bubble_if_id & ~rst;
    bubble_id_ex_o = bubble_id_ex & ~rst;
    pc_load_o      = pc_load & ~rst;
    pc_addr_o      = rst ? '0 : pc_addr;
  end

`ifdef PIPE_HOLD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall_pc_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl with ROM_WAIT=2.
// Output vector order: {stall_pc, stall_if_id, stall_id_ex, bubble_if_id, bubble_id_ex, pc_load}.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_req = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        ex_busy = 1'b0;
  logic        bus_wait = 1'b0;
  logic        stall_pc, stall_if_id, stall_id_ex, bubble_if_id, bubble_id_ex, pc_load;
  logic [31:0] pc_addr;
`ifdef PIPE_HOLD_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hold_ctrl #(.AW(32), .ROM_WAIT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_req_i    (jump_req),
    .jump_addr_i   (jump_addr),
    .ex_busy_i     (ex_busy),
    .bus_wait_i    (bus_wait),
    .stall_pc_o    (stall_pc),
    .stall_if_id_o (stall_if_id),
    .stall_id_ex_o (stall_id_ex),
    .bubble_if_id_o(bubble_if_id),
    .bubble_id_ex_o(bubble_id_ex),
    .pc_load_o     (pc_load),
`ifdef PIPE_HOLD_CTRL_PERF_EN
    .stall_cycles_o(stall_cycles),
`endif
    .pc_addr_o     (pc_addr)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] STL  = 6'b111000;
  localparam logic [5:0] LOAD = 6'b000111;
  localparam logic [5:0] BIF  = 6'b000100;

  function automatic logic [5:0] outs();
    return {stall_pc, stall_if_id, stall_id_ex, bubble_if_id, bubble_id_ex, pc_load};
  endfunction

  // Drive inputs (called just after a rising edge) and move to the sampling edge.
  task automatic apply(input logic j, input logic bw, input logic busy, input logic [31:0] a);
    jump_req  = j;
    bus_wait  = bw;
    ex_busy   = busy;
    jump_addr = a;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
      total++;
      if ({outs(), pc_addr} !== {IDLE, 32'h0}) begin
        bad++;
        $display("FAIL reset_hold c%0d outs=%b addr=%h want outs=%b addr=0", c, outs(), pc_addr, IDLE);
      end
      advance();
    end
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if ({outs(), 2'(dut.state_q)} !== {IDLE, 2'd0}) begin
      bad++;
      $display("FAIL reset_release outs=%b state=%0d want outs=%b state=0", outs(), dut.state_q, IDLE);
    end
    advance();
  endtask

  task automatic test_ex_busy();
    for (int c = 0; c < 6; c++) begin
      apply(1'b0, 1'b0, c < 5, 32'h0);
      total++;
      if (outs() !== ((c < 5) ? STL : IDLE)) begin
        bad++;
        $display("FAIL ex_busy c%0d outs=%b want %b", c, outs(), (c < 5) ? STL : IDLE);
      end
      advance();
    end
`ifdef PIPE_HOLD_CTRL_PERF_EN
    total++;
    if (stall_cycles !== 32'd5) begin
      bad++;
      $display("FAIL perf_count got=%0d want=5", stall_cycles);
    end
`endif
  endtask

  task automatic test_jump();
    logic [5:0]  exp_o [4] = '{LOAD, BIF, BIF, IDLE};
    logic [31:0] exp_a [4] = '{32'h100, 32'h0, 32'h0, 32'h0};
    for (int c = 0; c < 4; c++) begin
      apply(c == 0, 1'b0, 1'b0, (c == 0) ? 32'h0000_0100 : 32'hFFFF_0000);
      total++;
      if ({outs(), pc_addr} !== {exp_o[c], exp_a[c]}) begin
        bad++;
        $display("FAIL jump c%0d outs=%b addr=%h want outs=%b addr=%h", c, outs(), pc_addr, exp_o[c], exp_a[c]);
      end
      advance();
    end
  endtask

  task automatic test_bus_wait_jump();
    logic [2:0]  in_v  [7] = '{3'b110, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [5:0]  exp_o [7] = '{STL, STL, STL, LOAD, BIF, BIF, IDLE};
    logic [31:0] exp_a [7] = '{32'h0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0};
    for (int c = 0; c < 7; c++) begin
      apply(in_v[c][2], in_v[c][1], in_v[c][0], (c == 0) ? 32'h200 : 32'h0);
      total++;
      if ({outs(), pc_addr} !== {exp_o[c], exp_a[c]}) begin
        bad++;
        $display("FAIL bus_wait_jump c%0d outs=%b addr=%h want outs=%b addr=%h", c, outs(), pc_addr, exp_o[c], exp_a[c]);
      end
      advance();
    end
  endtask

  task automatic test_redirect_wait();
    logic [2:0]  in_v  [6] = '{3'b100, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [5:0]  exp_o [6] = '{LOAD, STL, STL, BIF, BIF, IDLE};
    logic [31:0] exp_a [6] = '{32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int c = 0; c < 6; c++) begin
      apply(in_v[c][2], in_v[c][1], in_v[c][0], (c == 0) ? 32'h40 : 32'h0);
      total++;
      if ({outs(), pc_addr} !== {exp_o[c], exp_a[c]}) begin
        bad++;
        $display("FAIL redirect_wait c%0d outs=%b addr=%h want outs=%b addr=%h", c, outs(), pc_addr, exp_o[c], exp_a[c]);
      end
      advance();
    end
  endtask

  task automatic test_pend_overwrite();
    logic [2:0]  in_v  [6] = '{3'b110, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [31:0] addr  [6] = '{32'h500, 32'h600, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [5:0]  exp_o [6] = '{STL, STL, LOAD, BIF, BIF, IDLE};
    logic [31:0] exp_a [6] = '{32'h0, 32'h0, 32'h600, 32'h0, 32'h0, 32'h0};
    for (int c = 0; c < 6; c++) begin
      apply(in_v[c][2], in_v[c][1], in_v[c][0], addr[c]);
      total++;
      if ({outs(), pc_addr} !== {exp_o[c], exp_a[c]}) begin
        bad++;
        $display("FAIL pend_overwrite c%0d outs=%b addr=%h want outs=%b addr=%h", c, outs(), pc_addr, exp_o[c], exp_a[c]);
      end
      advance();
    end
  endtask

  task automatic test_reset_in_pend();
    apply(1'b1, 1'b1, 1'b0, 32'h300);
    total++;
    if (outs() !== STL) begin
      bad++;
      $display("FAIL rst_pend_enter outs=%b want %b", outs(), STL);
    end
    advance();
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    total++;
    if (outs() !== STL) begin
      bad++;
      $display("FAIL rst_pend_wait outs=%b want %b", outs(), STL);
    end
    advance();
    rst = 1'b1;
    apply(1'b0, 1'b1, 1'b0, 32'h0);
    total++;
    if ({outs(), pc_addr, dut.pend_addr_q, 2'(dut.state_q)} !== {IDLE, 32'h0, 32'h0, 2'd0}) begin
      bad++;
      $display("FAIL rst_pend_async outs=%b addr=%h pend=%h state=%0d want all 0",
               outs(), pc_addr, dut.pend_addr_q, dut.state_q);
    end
    advance();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if ({outs(), pc_addr, dut.pend_addr_q} !== {IDLE, 32'h0, 32'h0}) begin
        bad++;
        $display("FAIL rst_pend_release c%0d outs=%b addr=%h pend=%h want all 0",
                 c, outs(), pc_addr, dut.pend_addr_q);
      end
      advance();
    end
`ifdef PIPE_HOLD_CTRL_PERF_EN
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL perf_cleared got=%0d want=0", stall_cycles);
    end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_ex_busy();
    test_jump();
    test_bus_wait_jump();
    test_redirect_wait();
    test_pend_overwrite();
    test_reset_in_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
